// File: rtl/fft_pkg.sv
// Shared constants, the controller state type and the bit-reversal helper
// for the radix-2 FFT sequencing controller.
package fft_pkg;

    localparam int FFT_N                = 64;
    localparam int FFT_LOG2N            = 6;
    localparam int FFT_BFLY_LAT_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } fftState_e;

    // Samples land in RAM in bit-reversed order so the in-place
    // decimation-in-time butterflies produce natural-order results.
    function automatic logic [FFT_LOG2N-1:0] bitrev6(input logic [FFT_LOG2N-1:0] v);
        logic [FFT_LOG2N-1:0] r;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            r[i] = v[FFT_LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: maps (stage, butterfly index)
// to the two operand addresses and the twiddle ROM index.
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic [2:0]           stage_i,
    input  logic [FFT_LOG2N-2:0] k_i,
    output logic [FFT_LOG2N-1:0] a_o,
    output logic [FFT_LOG2N-1:0] b_o,
    output logic [FFT_LOG2N-2:0] tw_o
);

    localparam logic [FFT_LOG2N-1:0] ONE = 1;

    logic [FFT_LOG2N-1:0] span;
    logic [FFT_LOG2N-1:0] kWide;
    logic [FFT_LOG2N-1:0] pos;
    logic [FFT_LOG2N-1:0] groupBase;

    // Butterflies are grouped in blocks of 2*span; a sits in the lower half
    // of its block, b exactly one span above, and the twiddle step shrinks
    // as the span grows.
    always_comb begin
        span      = ONE << stage_i;
        kWide     = {1'b0, k_i};
        pos       = kWide & (span - ONE);
        groupBase = (kWide >> stage_i) << (stage_i + 3'd1);
        a_o       = groupBase | pos;
        b_o       = a_o | span;
        tw_o      = pos[FFT_LOG2N-2:0] << (3'(FFT_LOG2N - 1) - stage_i);
    end

endmodule

// File: rtl/fft_ctrl.sv
// FFT sequencing controller: loads samples in bit-reversed order, walks the
// in-place butterfly schedule stage by stage with a write-back delay line,
// then lets the host read the result buffer out in order.
module fft_ctrl #(
    parameter int  N        = fft_pkg::FFT_N,
    parameter int  BFLY_LAT = fft_pkg::FFT_BFLY_LAT_DEFAULT,
    localparam int LOG2N    = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             sample_valid,
    output logic             load_we,
    output logic [LOG2N-1:0] load_addr,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wb_we,
    output logic [LOG2N-1:0] wb_addr_a,
    output logic [LOG2N-1:0] wb_addr_b,
    input  logic             read_next,
    output logic [LOG2N-1:0] out_addr,
    output logic             busy,
    output logic             done
);

    import fft_pkg::*;

    localparam logic [LOG2N-1:0] LAST_SAMPLE = LOG2N'(N - 1);
    localparam logic [LOG2N-2:0] LAST_K      = (LOG2N - 1)'(N / 2 - 1);
    localparam logic [2:0]       LAST_STAGE  = 3'(LOG2N - 1);
    localparam logic [2:0]       LAST_DRAIN  = 3'(BFLY_LAT - 1);

    fftState_e        state_q, state_d;
    logic [LOG2N-1:0] sampleCnt_q, sampleCnt_d;
    logic [2:0]       stage_q, stage_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [2:0]       drain_q, drain_d;
    logic [LOG2N-1:0] outAddr_q, outAddr_d;

    logic [BFLY_LAT-1:0] pipeValid_q;
    logic [LOG2N-1:0]    pipeA_q [BFLY_LAT];
    logic [LOG2N-1:0]    pipeB_q [BFLY_LAT];

    logic             loadEn;
    logic             issueEn;
    logic [LOG2N-1:0] genA;
    logic [LOG2N-1:0] genB;
    logic [LOG2N-2:0] genTw;

    assign loadEn  = reset && !clear && sample_valid && (state_q == IDLE || state_q == LOAD);
    assign issueEn = (state_q == COMPUTE);

    fft_addr_gen u_addrGen (
        .stage_i (stage_q),
        .k_i     (k_q),
        .a_o     (genA),
        .b_o     (genB),
        .tw_o    (genTw)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear wins over every other input.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_valid) state_d = LOAD;
                end
                LOAD: begin
                    if (sample_valid && sampleCnt_q == LAST_SAMPLE) state_d = COMPUTE;
                end
                COMPUTE: begin
                    if (k_q == LAST_K) state_d = DRAIN;
                end
                DRAIN: begin
                    if (drain_q == LAST_DRAIN) begin
                        state_d = (stage_q == LAST_STAGE) ? DONE : COMPUTE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Counter registers for sample, stage, butterfly, drain and readout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sampleCnt_q <= '0;
            stage_q     <= '0;
            k_q         <= '0;
            drain_q     <= '0;
            outAddr_q   <= '0;
        end else begin
            sampleCnt_q <= sampleCnt_d;
            stage_q     <= stage_d;
            k_q         <= k_d;
            drain_q     <= drain_d;
            outAddr_q   <= outAddr_d;
        end
    end

    // Counter next values; clear returns everything to the reset state.
    always_comb begin
        sampleCnt_d = sampleCnt_q;
        stage_d     = stage_q;
        k_d         = k_q;
        drain_d     = drain_q;
        outAddr_d   = outAddr_q;
        if (clear) begin
            sampleCnt_d = '0;
            stage_d     = '0;
            k_d         = '0;
            drain_d     = '0;
            outAddr_d   = '0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (loadEn) sampleCnt_d = sampleCnt_q + 1'b1;
                end
                COMPUTE: begin
                    k_d = k_q + 1'b1;
                    if (k_q == LAST_K) drain_d = '0;
                end
                DRAIN: begin
                    if (drain_q == LAST_DRAIN) begin
                        drain_d = '0;
                        stage_d = (stage_q == LAST_STAGE) ? 3'd0 : stage_q + 3'd1;
                    end else begin
                        drain_d = drain_q + 3'd1;
                    end
                end
                DONE: begin
                    if (read_next) outAddr_d = outAddr_q + 1'b1;
                end
                default: begin
                    sampleCnt_d = '0;
                end
            endcase
        end
    end

    // Write-back delay line: each issue reappears BFLY_LAT cycles later;
    // clear flushes it so no stale write-back escapes an abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipeValid_q <= '0;
            for (int i = 0; i < BFLY_LAT; i++) begin
                pipeA_q[i] <= '0;
                pipeB_q[i] <= '0;
            end
        end else if (clear) begin
            pipeValid_q <= '0;
            for (int i = 0; i < BFLY_LAT; i++) begin
                pipeA_q[i] <= '0;
                pipeB_q[i] <= '0;
            end
        end else begin
            pipeValid_q[0] <= issueEn;
            pipeA_q[0]     <= genA;
            pipeB_q[0]     <= genB;
            for (int i = 1; i < BFLY_LAT; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeA_q[i]     <= pipeA_q[i-1];
                pipeB_q[i]     <= pipeB_q[i-1];
            end
        end
    end

    // Outputs; every bus is forced to zero whenever its strobe or state is inactive.
    always_comb begin
        load_we   = loadEn;
        load_addr = loadEn ? bitrev6(sampleCnt_q) : '0;
        rd_addr_a = issueEn ? genA : '0;
        rd_addr_b = issueEn ? genB : '0;
        tw_addr   = issueEn ? genTw : '0;
        wb_we     = pipeValid_q[BFLY_LAT-1];
        wb_addr_a = pipeValid_q[BFLY_LAT-1] ? pipeA_q[BFLY_LAT-1] : '0;
        wb_addr_b = pipeValid_q[BFLY_LAT-1] ? pipeB_q[BFLY_LAT-1] : '0;
        out_addr  = (state_q == DONE) ? outAddr_q : '0;
        busy      = (state_q == COMPUTE) || (state_q == DRAIN);
        done      = (state_q == DONE);
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: randomized load gaps and stray inputs,
// checked against a schedule model built from the butterfly group structure.
module tb_fft_ctrl;

    localparam int LAT         = 2;
    localparam int NPTS        = 64;
    localparam int HALF        = 32;
    localparam int STAGES      = 6;
    localparam int CYC_COMPUTE = STAGES * (HALF + LAT);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       sample_valid = 1'b0;
    logic       read_next = 1'b0;
    logic       load_we;
    logic [5:0] load_addr;
    logic [5:0] rd_addr_a;
    logic [5:0] rd_addr_b;
    logic [4:0] tw_addr;
    logic       wb_we;
    logic [5:0] wb_addr_a;
    logic [5:0] wb_addr_b;
    logic [5:0] out_addr;
    logic       busy;
    logic       done;

    int vecCount = 0;
    int errCount = 0;

    fft_ctrl #(.N(NPTS), .BFLY_LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .sample_valid (sample_valid),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .tw_addr      (tw_addr),
        .wb_we        (wb_we),
        .wb_addr_a    (wb_addr_a),
        .wb_addr_b    (wb_addr_b),
        .read_next    (read_next),
        .out_addr     (out_addr),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] allOutputs();
        return {19'd0, load_we, load_addr, rd_addr_a, rd_addr_b, tw_addr,
                wb_we, wb_addr_a, wb_addr_b, out_addr, busy, done};
    endfunction

    function automatic int bitReverse(input int v);
        int r = 0;
        for (int i = 0; i < 6; i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    // Drive one cycle's inputs on the falling edge, leaving time to settle.
    task automatic applyStimulus(input logic sv, input logic rn, input logic clr);
        @(negedge clk);
        sample_valid = sv;
        read_next    = rn;
        clear        = clr;
        #1;
    endtask

    task automatic loadFrame();
        int   cnt = 0;
        int   guard = 0;
        logic sv;
        while (cnt < NPTS && guard < 2000) begin
            sv = ($urandom_range(0, 3) != 0);
            applyStimulus(sv, 1'($urandom_range(0, 1)), 1'b0);
            checkOutput("load_busy", busy, 1'b0);
            checkOutput("load_done", done, 1'b0);
            checkOutput("load_we", load_we, sv);
            if (sv) begin
                checkOutput("load_addr", load_addr, bitReverse(cnt));
                cnt++;
            end
            guard++;
        end
        if (cnt < NPTS) checkOutput("load_timeout", cnt, NPTS);
    endtask

    task automatic runCompute(input int abortAt);
        bit   issV [300];
        int   issA [300];
        int   issB [300];
        int   issT [300];
        bit   wbV  [300];
        int   wbA  [300];
        int   wbB  [300];
        int   c = 0;
        int   span;
        logic clr;
        for (int i = 0; i < 300; i++) begin
            issV[i] = 0; issA[i] = 0; issB[i] = 0; issT[i] = 0;
            wbV[i] = 0;  wbA[i] = 0;  wbB[i] = 0;
        end
        for (int s = 0; s < STAGES; s++) begin
            span = 1 << s;
            for (int g = 0; g < NPTS; g += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    issV[c] = 1;
                    issA[c] = g + j;
                    issB[c] = g + j + span;
                    issT[c] = j * (HALF / span);
                    wbV[c + LAT] = 1;
                    wbA[c + LAT] = g + j;
                    wbB[c + LAT] = g + j + span;
                    c++;
                end
            end
            c += LAT;
        end
        for (int cyc = 0; cyc < CYC_COMPUTE; cyc++) begin
            clr = (cyc == abortAt);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), clr);
            checkOutput("compute_busy", busy, 1'b1);
            checkOutput("compute_done", done, 1'b0);
            checkOutput("compute_load_we", load_we, 1'b0);
            checkOutput("compute_out_addr", out_addr, 6'd0);
            if (issV[cyc]) begin
                checkOutput("rd_addr_a", rd_addr_a, issA[cyc]);
                checkOutput("rd_addr_b", rd_addr_b, issB[cyc]);
                checkOutput("tw_addr", tw_addr, issT[cyc]);
            end else begin
                checkOutput("drain_rd_idle", {rd_addr_a, rd_addr_b, tw_addr}, 17'd0);
            end
            checkOutput("wb_we", wb_we, wbV[cyc]);
            if (wbV[cyc]) begin
                checkOutput("wb_addr_a", wb_addr_a, wbA[cyc]);
                checkOutput("wb_addr_b", wb_addr_b, wbB[cyc]);
            end
            if (clr) break;
        end
        if (abortAt >= 0) begin
            for (int i = 0; i < 8; i++) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                checkOutput("abort_busy", busy, 1'b0);
                checkOutput("abort_wb_we", wb_we, 1'b0);
                checkOutput("abort_rd_idle", {rd_addr_a, rd_addr_b, tw_addr}, 17'd0);
                checkOutput("abort_done", done, 1'b0);
            end
        end else begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            checkOutput("done_entry", done, 1'b1);
            checkOutput("done_busy", busy, 1'b0);
            checkOutput("done_load_we", load_we, 1'b0);
        end
    endtask

    task automatic runDone();
        int   outExp = 0;
        int   pulses = 0;
        int   guard = 0;
        logic rn;
        while (pulses < 65 && guard < 1000) begin
            rn = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 1)), rn, 1'b0);
            checkOutput("out_addr", out_addr, outExp);
            checkOutput("done_hold", done, 1'b1);
            checkOutput("done_load_we", load_we, 1'b0);
            if (rn) begin
                pulses++;
                outExp = (outExp + 1) % NPTS;
            end
            guard++;
        end
        if (pulses < 65) checkOutput("read_timeout", pulses, 65);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("out_addr_wrapped", out_addr, outExp);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("clear_drops_sample", load_we, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("after_clear_outputs", allOutputs(), 64'd0);
    endtask

    initial begin
        sample_valid = 1'b1;
        #12;
        checkOutput("reset_outputs", allOutputs(), 64'd0);
        sample_valid = 1'b0;
        #10;
        reset = 1'b1;

        loadFrame();
        runCompute(-1);
        runDone();

        loadFrame();
        runCompute(50);
        loadFrame();
        runCompute(-1);
        runDone();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("partial_load_addr", load_addr, bitReverse(i));
        end
        @(negedge clk);
        sample_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_outputs", allOutputs(), 64'd0);
        @(negedge clk);
        sample_valid = 1'b0;
        #2;
        reset = 1'b1;

        loadFrame();
        runCompute(-1);
        runDone();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
